seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 253 +++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready request and result handshake.
//
// An operation is accepted when in_valid && in_ready (in_ready is high only in
// IDLE). Single-cycle operations register their result and flags on the
// accepting edge, so out_valid is high the following cycle. The result is held
// in DONE until out_ready is seen, after which the block returns to IDLE.
//
// Opcodes (ALUcntrl):
//   0000 add   0001 sll   0010 sub   0011 sra   0100 xor
//   0101 srl   0110 or    0111 and   1000 mul (optional)   others -> 0
// Shift amount is srcB[SHW-1:0]; upper srcB bits are ignored.
//
// Optional feature macro: SEQ_ALU_MUL_EN
//   Defined   : opcode 1000 runs a shift-add multiplier, one multiplier bit
//               per cycle (IDLE -> BUSY x WIDTH -> DONE); ALUrslt is the low
//               half of the unsigned product, carryflag flags a nonzero high
//               half.
//   Undefined : opcode 1000 behaves like any undefined opcode (result 0,
//               single-cycle) and BUSY is never entered.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operation request
//   in_ready   out  request accepted this cycle (IDLE only)
//   srcA       in   operand A                        [WIDTH]
//   srcB       in   operand B / shift amount         [WIDTH]
//   ALUcntrl   in   opcode                           [4]
//   out_valid  out  ALUrslt and flags valid (DONE)
//   out_ready  in   consumer accepts the result
//   ALUrslt    out  registered result                [WIDTH]
//   zeroflag   out  ALUrslt == 0
//   signflag   out  ALUrslt[WIDTH-1]
//   carryflag  out  add carry / sub borrow / mul high half nonzero
//   ovflag     out  signed overflow for add and sub
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic [3:0]       ALUcntrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUrslt,
   output logic             zeroflag,
   output logic             signflag,
   output logic             carryflag,
   output logic             ovflag
);

   // ---------------------------------------------------------------------------
   // State encoding and opcodes
   // ---------------------------------------------------------------------------
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SRA = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0111;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1000;
`endif

   logic [1:0]       state;
   logic [WIDTH-1:0] rslt_q;
   logic             zero_q;
   logic             sign_q;
   logic             carry_q;
   logic             ov_q;

   logic             accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   assign ALUrslt   = rslt_q;
   assign zeroflag  = zero_q;
   assign signflag  = sign_q;
   assign carryflag = carry_q;
   assign ovflag    = ov_q;

   // ---------------------------------------------------------------------------
   // Single-cycle datapath, evaluated on the live inputs; its outputs are only
   // registered on the accepting edge.
   // ---------------------------------------------------------------------------
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [WIDTH-1:0] sra_val;
   logic [WIDTH-1:0] alu_rslt;
   logic             alu_carry;
   logic             alu_ov;

   assign shamt    = srcB[SHW-1:0];
   assign add_full = {1'b0, srcA} + {1'b0, srcB};
   // The extra top bit of an unsigned subtraction is the borrow (srcA < srcB).
   assign sub_full = {1'b0, srcA} - {1'b0, srcB};
   assign sra_val  = $unsigned($signed(srcA) >>> shamt);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      alu_rslt  = '0;
      alu_carry = 1'b0;
      alu_ov    = 1'b0;
      unique case (ALUcntrl)
         OP_ADD: begin
            alu_rslt  = add_full[WIDTH-1:0];
            alu_carry = add_full[WIDTH];
            // Overflow: operands share a sign the result does not.
            alu_ov    = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                        (add_full[WIDTH-1] != srcA[WIDTH-1]);
         end
         OP_SUB: begin
            alu_rslt  = sub_full[WIDTH-1:0];
            alu_carry = sub_full[WIDTH];
            // Overflow: operand signs differ and the result sign flips from A.
            alu_ov    = (srcA[WIDTH-1] != srcB[WIDTH-1]) &&
                        (sub_full[WIDTH-1] != srcA[WIDTH-1]);
         end
         OP_SLL:  alu_rslt = srcA << shamt;
         OP_SRL:  alu_rslt = srcA >> shamt;
         OP_SRA:  alu_rslt = sra_val;
         OP_XOR:  alu_rslt = srcA ^ srcB;
         OP_OR:   alu_rslt = srcA | srcB;
         OP_AND:  alu_rslt = srcA & srcB;
         // Undefined opcodes (and 1000 here, which the multiplier handles
         // separately when present) keep the zero defaults.
         default: alu_rslt = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Multiplier interface to the control FSM
   // ---------------------------------------------------------------------------
   logic             is_mul;     // accepted opcode goes through BUSY
   logic             mul_last;   // current BUSY cycle consumes the final bit
   logic [WIDTH-1:0] mul_rslt;   // low product half after the final step
   logic             mul_carry;  // high product half nonzero

`ifdef SEQ_ALU_MUL_EN
   // Classic right-shifting shift-add: {prod_hi, prod_lo} starts as {0, B};
   // each cycle adds A into the high half when the current multiplier bit
   // (prod_lo[0]) is set, then shifts the whole pair right by one. After
   // WIDTH steps the pair holds the full 2*WIDTH-bit unsigned product.
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;
   logic [SHW-1:0]   bit_cnt;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] next_hi;
   logic [WIDTH-1:0] next_lo;

   assign step_sum  = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
   assign next_hi   = step_sum[WIDTH:1];
   assign next_lo   = {step_sum[0], prod_lo[WIDTH-1:1]};

   assign is_mul    = (ALUcntrl == OP_MUL);
   assign mul_last  = (bit_cnt == {SHW{1'b1}});
   assign mul_rslt  = next_lo;
   assign mul_carry = |next_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         prod_hi <= '0;
         prod_lo <= '0;
         bit_cnt <= '0;
      end else if (accept && is_mul) begin
         // Operands are captured here; srcA/srcB may change while BUSY.
         mcand   <= srcA;
         prod_hi <= '0;
         prod_lo <= srcB;
         bit_cnt <= '0;
      end else if (state == BUSY) begin
         prod_hi <= next_hi;
         prod_lo <= next_lo;
         bit_cnt <= bit_cnt + 1'b1;
      end
   end
`else
   assign is_mul    = 1'b0;
   assign mul_last  = 1'b1;
   assign mul_rslt  = '0;
   assign mul_carry = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Control FSM and result/flag registers. The result registers only change
   // on acceptance or on the last multiplier step, so they hold throughout
   // DONE regardless of out_ready.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      if (rst) begin
         state   <= IDLE;
         rslt_q  <= '0;
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
         carry_q <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state <= BUSY;
                  end else begin
                     state   <= DONE;
                     rslt_q  <= alu_rslt;
                     zero_q  <= (alu_rslt == '0);
                     sign_q  <= alu_rslt[WIDTH-1];
                     carry_q <= alu_carry;
                     ov_q    <= alu_ov;
                  end
               end
            end
            BUSY: begin
               if (mul_last) begin
                  state   <= DONE;
                  rslt_q  <= mul_rslt;
                  zero_q  <= (mul_rslt == '0);
                  sign_q  <= mul_rslt[WIDTH-1];
                  carry_q <= mul_carry;
                  ov_q    <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu.
// A 32-bit instance carries most scenarios; an 8-bit instance covers the
// narrow-width cases. Expected results come from a width-generic arithmetic
// model working on 64-bit integers. Outputs are sampled on the falling edge.
// Multiplier scenarios follow SEQ_ALU_MUL_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_seq_alu;

   typedef struct packed {
      logic [31:0] r;
      logic        z;
      logic        s;
      logic        c;
      logic        v;
   } res_t;

`ifdef SEQ_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   localparam int MAX_WAIT = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // 32-bit instance
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [31:0] srcA      = '0;
   logic [31:0] srcB      = '0;
   logic [3:0]  ALUcntrl  = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ALUrslt;
   logic        zeroflag, signflag, carryflag, ovflag;

   // 8-bit instance
   logic        in_valid8  = 1'b0;
   logic        in_ready8;
   logic [7:0]  srcA8      = '0;
   logic [7:0]  srcB8      = '0;
   logic [3:0]  ALUcntrl8  = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b0;
   logic [7:0]  ALUrslt8;
   logic        zeroflag8, signflag8, carryflag8, ovflag8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .srcA(srcA), .srcB(srcB), .ALUcntrl(ALUcntrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALUrslt(ALUrslt),
      .zeroflag(zeroflag), .signflag(signflag),
      .carryflag(carryflag), .ovflag(ovflag)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .srcA(srcA8), .srcB(srcB8), .ALUcntrl(ALUcntrl8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .ALUrslt(ALUrslt8),
      .zeroflag(zeroflag8), .signflag(signflag8),
      .carryflag(carryflag8), .ovflag(ovflag8)
   );

   // ---------------------------------------------------------------------------
   // Reference model: plain integer arithmetic at width w (8..32).
   // ---------------------------------------------------------------------------
   function automatic res_t model(input int w, input logic [3:0] op,
                                  input logic [31:0] ai, input logic [31:0] bi);
      logic [63:0] mask, a, b, full, r;
      longint      sa, sb, sr, smax, smin;
      int          sh;
      res_t        res;
      mask = (64'd1 << w) - 64'd1;
      a    = {32'd0, ai} & mask;
      b    = {32'd0, bi} & mask;
      sa   = a[w-1] ? longint'(a) - longint'(mask) - 1 : longint'(a);
      sb   = b[w-1] ? longint'(b) - longint'(mask) - 1 : longint'(b);
      smax = longint'(mask >> 1);
      smin = -smax - 1;
      sh   = int'(b % 64'(w));
      res  = '0;
      r    = '0;
      case (op)
         4'h0: begin
            full  = a + b;
            res.c = full[w];
            sr    = sa + sb;
            res.v = (sr > smax) || (sr < smin);
            r     = full;
         end
         4'h1: r = a << sh;
         4'h2: begin
            r     = a - b;
            res.c = (a < b);
            sr    = sa - sb;
            res.v = (sr > smax) || (sr < smin);
         end
         4'h3: begin
            sr = sa >>> sh;
            r  = 64'(sr);
         end
         4'h4: r = a ^ b;
         4'h5: r = a >> sh;
         4'h6: r = a | b;
         4'h7: r = a & b;
         4'h8: begin
            if (MUL_EN) begin
               full  = a * b;
               res.c = ((full >> w) != 64'd0);
               r     = full;
            end
         end
         default: r = '0;
      endcase
      r     = r & mask;
      res.r = r[31:0];
      res.z = (r == 64'd0);
      res.s = r[w-1];
      return res;
   endfunction

   function automatic int exp_lat(input logic [3:0] op);
      return (op == 4'h8 && MUL_EN) ? 33 : 1;
   endfunction

   // Drive one request on the 32-bit instance (assumed IDLE), scramble the
   // inputs after acceptance and wait for out_valid. Returns the latency in
   // cycles from the accepting edge; MAX_WAIT means it never came.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
      @(negedge clk);
      ALUcntrl = op; srcA = a; srcB = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      srcA = $urandom; srcB = $urandom; ALUcntrl = 4'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      // A request held during reset must not be taken.
      in_valid = 1'b1; ALUcntrl = 4'h0; srcA = 32'h5; srcB = 32'h7;
      repeat (3) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_hs: in_ready/out_valid=%b expected 10", {in_ready, out_valid});
      end
      checks++;
      if ({ALUrslt, zeroflag, signflag, carryflag, ovflag} !== 36'd0) begin
         errors++;
         $display("FAIL reset_regs: rslt=%h flags=%b expected 0", ALUrslt,
                  {zeroflag, signflag, carryflag, ovflag});
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_priority: out_valid=%b out_valid8=%b expected 0", out_valid, out_valid8);
      end
   endtask

   task automatic test_directed();
      logic [3:0]  ops [4] = '{4'h0, 4'h2, 4'h3, 4'h5};
      logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [4] = '{32'h1, 32'hFFFF_FFFF, 32'h24, 32'h24};
      res_t        exp [4] = '{{32'h0, 1'b1, 1'b0, 1'b1, 1'b0},
                               {32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1},
                               {32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0},
                               {32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i], lat);
         checks++;
         if (lat !== 1) begin
            errors++;
            $display("FAIL directed_lat[%0d]: latency %0d expected 1", i, lat);
         end
         checks++;
         if ({ALUrslt, zeroflag, signflag, carryflag, ovflag} !== exp[i]) begin
            errors++;
            $display("FAIL directed_res[%0d]: got %h/%b expected %h/%b", i, ALUrslt,
                     {zeroflag, signflag, carryflag, ovflag}, exp[i].r,
                     {exp[i].z, exp[i].s, exp[i].c, exp[i].v});
         end
         consume();
      end
   endtask

   task automatic test_mul();
      int   lat;
      res_t exp;
`ifdef SEQ_ALU_MUL_EN
      exp = '{32'h0001_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      issue(4'h8, 32'h0001_0000, 32'h0001_0001, lat);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL mul_lat: latency %0d expected 33", lat);
      end
`else
      exp = '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
      issue(4'h8, 32'h0001_0000, 32'h0001_0001, lat);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL mul_lat: latency %0d expected 1", lat);
      end
`endif
      checks++;
      if ({ALUrslt, zeroflag, signflag, carryflag, ovflag} !== exp) begin
         errors++;
         $display("FAIL mul_res: got %h/%b expected %h/%b", ALUrslt,
                  {zeroflag, signflag, carryflag, ovflag}, exp.r, {exp.z, exp.s, exp.c, exp.v});
      end
      consume();
   endtask

`ifdef SEQ_ALU_MUL_EN
   task automatic test_mul_reset();
      int seen = 0;
      @(negedge clk);
      ALUcntrl = 4'h8; srcA = 32'hDEAD_BEEF; srcB = 32'h1234_5678; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || ALUrslt !== 32'h0) begin
         errors++;
         $display("FAIL mul_reset_idle: in_ready=%b rslt=%h expected 1/0", in_ready, ALUrslt);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mul_reset_pulse: out_valid high %0d cycles expected 0", seen);
      end
   endtask
`endif

   task automatic test_random();
      int          lat;
      res_t        exp;
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [31:0] edges [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 32'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 32'($urandom);
         exp = model(32, op, a, b);
         issue(op, a, b, lat);
         checks++;
         if (lat !== exp_lat(op)) begin
            errors++;
            $display("FAIL rand_lat[%0d] op=%h: latency %0d expected %0d", i, op, lat, exp_lat(op));
         end
         checks++;
         if ({ALUrslt, zeroflag, signflag, carryflag, ovflag} !== exp) begin
            errors++;
            $display("FAIL rand_res[%0d] op=%h a=%h b=%h: got %h/%b expected %h/%b", i, op, a, b,
                     ALUrslt, {zeroflag, signflag, carryflag, ovflag},
                     exp.r, {exp.z, exp.s, exp.c, exp.v});
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         consume();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_release[%0d]: out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_hold();
      int   lat;
      res_t exp;
      exp = model(32, 4'h2, 32'h1234_5678, 32'h8765_4321);
      issue(4'h2, 32'h1234_5678, 32'h8765_4321, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         ALUcntrl = 4'($urandom_range(0, 7)); srcA = $urandom; srcB = $urandom;
         @(negedge clk);
         checks++;
         if ({ALUrslt, zeroflag, signflag, carryflag, ovflag} !== exp ||
             out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got %h/%b ov=%b ir=%b expected %h/%b 1/0", i, ALUrslt,
                     {zeroflag, signflag, carryflag, ovflag}, out_valid, in_ready,
                     exp.r, {exp.z, exp.s, exp.c, exp.v});
         end
      end
      in_valid = 1'b0;
      consume();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_noqueue[%0d]: out_valid=%b expected 0", i, out_valid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      res_t       q [$];
      res_t       exp;
      logic [3:0] op;
      int         accepts = 0;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious[%0d]: out_valid with no request outstanding", i);
            end else begin
               exp = q.pop_front();
               if ({ALUrslt, zeroflag, signflag, carryflag, ovflag} !== exp) begin
                  errors++;
                  $display("FAIL b2b_res[%0d]: got %h/%b expected %h/%b", i, ALUrslt,
                           {zeroflag, signflag, carryflag, ovflag}, exp.r, {exp.z, exp.s, exp.c, exp.v});
               end
            end
         end
         op = 4'($urandom_range(0, 7));
         ALUcntrl = op; srcA = $urandom; srcB = $urandom; in_valid = 1'b1;
         if (in_ready === 1'b1) begin
            accepts++;
            q.push_back(model(32, op, srcA, srcB));
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (accepts != 10 || q.size() != 0) begin
         errors++;
         $display("FAIL b2b_rate: accepts=%0d pending=%0d expected 10/0", accepts, q.size());
      end
   endtask

   task automatic test_width8();
      logic [3:0] ops [3] = '{4'h7, 4'hF, 4'h0};
      logic [7:0] as  [3] = '{8'hF0, 8'hFF, 8'h7F};
      logic [7:0] bs  [3] = '{8'h0F, 8'hFF, 8'h01};
      res_t       exp;
      int         lat;
      for (int i = 0; i < 3; i++) begin
         exp = model(8, ops[i], {24'd0, as[i]}, {24'd0, bs[i]});
         @(negedge clk);
         ALUcntrl8 = ops[i]; srcA8 = as[i]; srcB8 = bs[i]; in_valid8 = 1'b1;
         @(negedge clk);
         in_valid8 = 1'b0;
         lat = 1;
         while (out_valid8 !== 1'b1 && lat < MAX_WAIT) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (lat !== 1 || {ALUrslt8, zeroflag8, signflag8, carryflag8, ovflag8} !== {exp.r[7:0], exp.z, exp.s, exp.c, exp.v}) begin
            errors++;
            $display("FAIL w8[%0d] op=%h: lat=%0d got %h/%b expected lat 1 %h/%b", i, ops[i], lat,
                     ALUrslt8, {zeroflag8, signflag8, carryflag8, ovflag8},
                     exp.r[7:0], {exp.z, exp.s, exp.c, exp.v});
         end
         out_ready8 = 1'b1;
         @(negedge clk);
         out_ready8 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mul();
`ifdef SEQ_ALU_MUL_EN
      test_mul_reset();
`endif
      test_hold();
      test_back_to_back();
      test_random();
      test_width8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
